// File: rtl/jogo_pkg.sv
// Shared definitions for the player-input path of the sequence-memory game:
// FSM encodings, default debounce window and the one-hot check helper.
package jogo_pkg;

   typedef enum logic [3:0] {
      ESPERA      = 4'd0,
      FILTRA      = 4'd1,
      PRESSIONADO = 4'd2,
      BLOQUEADO   = 4'd3
   } estado_t;

   localparam int unsigned N_BOTOES_PADRAO        = 4;
   localparam int unsigned DEBOUNCE_CICLOS_PADRAO = 50000;

   // Widest button vector the one-hot helper accepts; narrower vectors are zero-extended.
   localparam int unsigned MAX_BOTOES = 32;

   function automatic logic eh_one_hot(input logic [MAX_BOTOES-1:0] v);
      return (v != '0) && ((v & (v - MAX_BOTOES'(1))) == '0);
   endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, cleared by a
// synchronous active-low reset.
module sincronizador_2ff #(
   parameter int unsigned LARGURA = 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [LARGURA-1:0] d_i,
   output logic [LARGURA-1:0] q_o
);

   logic [LARGURA-1:0] meta_q;
   logic [LARGURA-1:0] sinc_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         meta_q <= '0;
         sinc_q <= '0;
      end else begin
         meta_q <= d_i;
         sinc_q <= meta_q;
      end
   end

   assign q_o = sinc_q;

endmodule

// File: rtl/detector_jogada.sv
// Player-button conditioning: synchronise, debounce press and release, emit one-hot
// jogada plus one pulso per press. PULSO_NA_SOLTURA_EN moves pulso to the release.
module detector_jogada
   import jogo_pkg::*;
#(
   parameter int unsigned N_BOTOES        = N_BOTOES_PADRAO,
   parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                habilita,
   input  logic [N_BOTOES-1:0] botoes,
   output logic [N_BOTOES-1:0] jogada,
   output logic                pulso,
   output logic                tem_jogada,
   output logic                invalida,
   output logic [3:0]          db_estado
);

   localparam int unsigned   CW      = $clog2(DEBOUNCE_CICLOS + 1);
   localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CICLOS - 1);

   logic [N_BOTOES-1:0] sinc;

   estado_t             estado_q, estado_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [N_BOTOES-1:0] cand_q, cand_d;
   logic [N_BOTOES-1:0] jogada_q, jogada_d;
   logic                pulso_q, pulso_d;
   logic                invalida_q, invalida_d;
   logic                tem_q;

   sincronizador_2ff #(
      .LARGURA (N_BOTOES)
   ) u_sinc (
      .clk_i  (clock),
      .rst_ni (reset),
      .d_i    (botoes),
      .q_o    (sinc)
   );

   always_comb begin
      estado_d   = estado_q;
      cnt_d      = cnt_q;
      cand_d     = cand_q;
      jogada_d   = jogada_q;
      pulso_d    = 1'b0;
      invalida_d = 1'b0;

      case (estado_q)
         ESPERA: begin
            cnt_d = '0;
            if (sinc != '0) begin
               cand_d   = sinc;
               estado_d = FILTRA;
            end
         end

         FILTRA: begin
            if (sinc == '0) begin
               cnt_d    = '0;
               estado_d = ESPERA;
            end else if (sinc != cand_q) begin
               cand_d = sinc;
               cnt_d  = '0;
            end else if (cnt_q == CNT_FIM) begin
               cnt_d = '0;
               if (eh_one_hot(MAX_BOTOES'(cand_q))) begin
                  jogada_d = cand_q;
                  estado_d = PRESSIONADO;
`ifndef PULSO_NA_SOLTURA_EN
                  pulso_d  = 1'b1;
`endif
               end else begin
                  invalida_d = 1'b1;
                  estado_d   = BLOQUEADO;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         // Release filter shared by both held states; any non-zero sample restarts it.
         PRESSIONADO, BLOQUEADO: begin
            if (sinc != '0) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_FIM) begin
               cnt_d    = '0;
               estado_d = ESPERA;
`ifdef PULSO_NA_SOLTURA_EN
               pulso_d  = (estado_q == PRESSIONADO);
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         default: begin
            cnt_d    = '0;
            estado_d = ESPERA;
         end
      endcase

      if (!habilita) begin
         estado_d   = ESPERA;
         cnt_d      = '0;
         jogada_d   = jogada_q;
         pulso_d    = 1'b0;
         invalida_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         estado_q   <= ESPERA;
         cnt_q      <= '0;
         cand_q     <= '0;
         jogada_q   <= '0;
         pulso_q    <= 1'b0;
         invalida_q <= 1'b0;
         tem_q      <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         cnt_q      <= cnt_d;
         cand_q     <= cand_d;
         jogada_q   <= jogada_d;
         pulso_q    <= pulso_d;
         invalida_q <= invalida_d;
         tem_q      <= (estado_d == PRESSIONADO);
      end
   end

   assign jogada     = jogada_q;
   assign pulso      = pulso_q;
   assign invalida   = invalida_q;
   assign tem_jogada = tem_q;
   assign db_estado  = estado_q;

endmodule
